// File: rtl/wb_stage_pkg.sv
// Shared types for the RV32 write-back stage: source select, FSM states,
// load funct3 encodings and the MEM/WB entry record.
package rv_wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_NPC = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    LWAIT = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            rf_we;
    wb_sel_t         wb_sel;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] csr;
    logic [4:0]      rd;
  } mem_wb_t;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_stage_load_fmt.sv
// Combinational load formatter: extracts byte/half/word from the aligned
// read word, extends it, and flags misaligned or undefined load encodings.
module load_fmt
  import rv_wb_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // funct3[2] selects zero extension; reserved encodings are treated as misaligned
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:   data = ext8(byte_s, 1'b1);
      F3_LBU:  data = ext8(byte_s, 1'b0);
      F3_LH: begin
        data     = ext16(half_s, 1'b1);
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = ext16(half_s, 1'b0);
        misalign = addr_lo[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'd0);
      end
      default: begin
        data     = '0;
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32 write-back stage: one MEM/WB entry, source select, load formatting,
// multi-cycle load wait with valid/ready back-pressure, and retire counter.
module wb_stage
  import rv_wb_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rf_we,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [N-1:0]     in_alu,
  input  logic [N-1:0]     in_npc,
  input  logic [N-1:0]     in_csr,
  input  logic [4:0]       in_rd,
  input  logic             mem_rvalid,
  input  logic [N-1:0]     mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [N-1:0]     rf_wdata,
  output logic             ld_pend,
  output logic [4:0]       ld_pend_rd,
  output logic             ld_misalign,
  output logic             rsp_orphan,
  output logic [CNT_W-1:0] instret
);

  if (N != 32) begin : g_bad_width
    $error("wb_stage: only N=32 is supported");
  end

  wb_state_t        state_q;
  mem_wb_t          entry_q;
  mem_wb_t          entry_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             orphan_q;

  logic             complete_s;
  logic             capture_s;
  logic [N-1:0]     fmt_data_s;
  logic             fmt_mis_s;
  logic             mis_s;
  logic [N-1:0]     src_s;

  load_fmt u_load_fmt (
    .rdata    (mem_rdata),
    .funct3   (entry_q.funct3),
    .addr_lo  (entry_q.addr_lo),
    .data     (fmt_data_s),
    .misalign (fmt_mis_s)
  );

  always_comb begin
    complete_s = 1'b0;
    case (state_q)
      EMPTY:   complete_s = 1'b0;
      HOLD:    complete_s = 1'b1;
      LWAIT:   complete_s = mem_rvalid;
      default: complete_s = 1'b0;
    endcase
  end

  assign in_ready  = (state_q == EMPTY) | complete_s;
  assign capture_s = in_valid & in_ready;
  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};

  assign entry_d = '{rf_we:   in_rf_we,
                     wb_sel:  wb_sel_t'(in_wb_sel),
                     funct3:  in_funct3,
                     addr_lo: in_addr_lo,
                     alu:     in_alu,
                     npc:     in_npc,
                     csr:     in_csr,
                     rd:      in_rd};

  always_comb begin
    src_s = '0;
    case (entry_q.wb_sel)
      WB_ALU:  src_s = entry_q.alu;
      WB_MEM:  src_s = fmt_data_s;
      WB_NPC:  src_s = entry_q.npc;
      WB_CSR:  src_s = entry_q.csr;
      default: src_s = '0;
    endcase
  end

  // Misalignment only matters for entries that actually take load data
  assign mis_s = (entry_q.wb_sel == WB_MEM) & fmt_mis_s;

  // A response that arrives while no load is waiting (including the capture
  // cycle of a new load) belongs to no entry and is latched as an orphan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      entry_q   <= '0;
      instret_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      if (capture_s) begin
        entry_q <= entry_d;
        state_q <= (wb_sel_t'(in_wb_sel) == WB_MEM) ? LWAIT : HOLD;
      end else if (complete_s) begin
        state_q <= EMPTY;
      end
      if (complete_s) begin
        instret_q <= instret_d;
      end
      if (mem_rvalid && (state_q != LWAIT)) begin
        orphan_q <= 1'b1;
      end
    end
  end

  assign rf_we       = complete_s & entry_q.rf_we & (entry_q.rd != 5'd0) & ~mis_s;
  assign rf_rd       = complete_s ? entry_q.rd : 5'd0;
  assign rf_wdata    = complete_s ? src_s : '0;
  assign ld_misalign = complete_s & mis_s;
  assign ld_pend     = (state_q == LWAIT);
  assign ld_pend_rd  = ld_pend ? entry_q.rd : 5'd0;
  assign rsp_orphan  = orphan_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/NPC/CSR writes, load formatting, load wait,
// misalignment, orphan responses, reset mid-load and counter wrap.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_rf_we;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu;
  logic [31:0] in_npc;
  logic [31:0] in_csr;
  logic [4:0]  in_rd;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        ld_pend;
  logic [4:0]  ld_pend_rd;
  logic        ld_misalign;
  logic        rsp_orphan;
  logic [63:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage #(.N(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rf_we(in_rf_we), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_npc(in_npc), .in_csr(in_csr),
    .in_rd(in_rd), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .ld_pend(ld_pend), .ld_pend_rd(ld_pend_rd), .ld_misalign(ld_misalign),
    .rsp_orphan(rsp_orphan), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then drive.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] npc, input logic [31:0] csr);
    in_valid   = v;
    in_rf_we   = we;
    in_wb_sel  = sel;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_rd      = rd;
    in_alu     = alu;
    in_npc     = npc;
    in_csr     = csr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd);
    drive(1'b1, 1'b1, 2'd1, f3, lo, rd, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    nxt();
    nxt();
    settle();
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check_val("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    check_val("rst_instret", instret, 64'd0);
    check_val("rst_orphan", {63'd0, rsp_orphan}, 64'd0);
    check_val("rst_ld_pend", {63'd0, ld_pend}, 64'd0);

    // Single ALU op
    nxt();
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd5, 32'h0000_1234, 32'h0000_5555, 32'h0000_6666);
    nxt();
    idle();
    settle();
    check_val("alu_we", {63'd0, rf_we}, 64'd1);
    check_val("alu_rd", {59'd0, rf_rd}, 64'd5);
    check_val("alu_wdata", {32'd0, rf_wdata}, 64'h1234);
    nxt();
    settle();
    check_val("alu_instret", instret, 64'd1);
    check_val("alu_we_after", {63'd0, rf_we}, 64'd0);

    // LB at offset 3, response three cycles after capture
    load(3'b000, 2'd3, 5'd7);
    nxt();
    idle();
    for (int i = 0; i < 2; i++) begin
      settle();
      check_val("lb_wait_ready", {63'd0, in_ready}, 64'd0);
      check_val("lb_wait_pend", {63'd0, ld_pend}, 64'd1);
      check_val("lb_wait_pend_rd", {59'd0, ld_pend_rd}, 64'd7);
      check_val("lb_wait_we", {63'd0, rf_we}, 64'd0);
      nxt();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_FF7F;
    settle();
    check_val("lb_ready", {63'd0, in_ready}, 64'd1);
    check_val("lb_we", {63'd0, rf_we}, 64'd1);
    check_val("lb_rd", {59'd0, rf_rd}, 64'd7);
    check_val("lb_wdata", {32'd0, rf_wdata}, 64'hFFFF_FF80);
    nxt();
    idle();
    settle();
    check_val("lb_pend_clr", {63'd0, ld_pend}, 64'd0);
    check_val("lb_pend_rd_clr", {59'd0, ld_pend_rd}, 64'd0);
    check_val("lb_instret", instret, 64'd2);
    check_val("lb_no_orphan", {63'd0, rsp_orphan}, 64'd0);

    // LHU offset 2
    load(3'b101, 2'd2, 5'd9);
    nxt();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF_0000;
    settle();
    check_val("lhu_we", {63'd0, rf_we}, 64'd1);
    check_val("lhu_wdata", {32'd0, rf_wdata}, 64'h0000_BEEF);

    // LW offset 1 captured back-to-back as the LHU completes: misaligned
    load(3'b010, 2'd1, 5'd10);
    nxt();
    idle();
    settle();
    check_val("lw_mis_wait", {63'd0, ld_misalign}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    settle();
    check_val("lw_mis_pulse", {63'd0, ld_misalign}, 64'd1);
    check_val("lw_mis_we", {63'd0, rf_we}, 64'd0);

    // LH offset 0 sign-extends
    load(3'b001, 2'd0, 5'd11);
    nxt();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_8001;
    settle();
    check_val("lh_mis_clr", {63'd0, ld_misalign}, 64'd0);
    check_val("lh_wdata", {32'd0, rf_wdata}, 64'hFFFF_8001);
    nxt();
    idle();
    settle();
    check_val("ld_instret", instret, 64'd5);

    // Four back-to-back ops with in_valid held; last has rd=0
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd1, 32'h0000_00A1, 32'h0000_00B1, 32'h0000_00C1);
    nxt();
    settle();
    check_val("b2b0_we", {63'd0, rf_we}, 64'd1);
    check_val("b2b0_wdata", {32'd0, rf_wdata}, 64'hA1);
    check_val("b2b0_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 1'b1, 2'd2, 3'd0, 2'd0, 5'd2, 32'h0000_00A2, 32'h0000_00B2, 32'h0000_00C2);
    nxt();
    settle();
    check_val("b2b1_rd", {59'd0, rf_rd}, 64'd2);
    check_val("b2b1_wdata", {32'd0, rf_wdata}, 64'hB2);
    drive(1'b1, 1'b1, 2'd3, 3'd0, 2'd0, 5'd3, 32'h0000_00A3, 32'h0000_00B3, 32'h0000_00C3);
    nxt();
    settle();
    check_val("b2b2_rd", {59'd0, rf_rd}, 64'd3);
    check_val("b2b2_wdata", {32'd0, rf_wdata}, 64'hC3);
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0000_00A4, 32'h0000_00B4, 32'h0000_00C4);
    nxt();
    idle();
    settle();
    check_val("b2b3_we", {63'd0, rf_we}, 64'd0);
    nxt();
    settle();
    check_val("b2b_instret", instret, 64'd9);

    // Orphan response while EMPTY
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    settle();
    check_val("orph_we", {63'd0, rf_we}, 64'd0);
    nxt();
    idle();
    settle();
    check_val("orph_set", {63'd0, rsp_orphan}, 64'd1);
    nxt();
    settle();
    check_val("orph_sticky", {63'd0, rsp_orphan}, 64'd1);
    check_val("orph_instret", instret, 64'd9);

    // Reset during LWAIT drops the entry; later response is an orphan
    load(3'b000, 2'd0, 5'd12);
    nxt();
    idle();
    settle();
    check_val("rstw_pend", {63'd0, ld_pend}, 64'd1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    settle();
    check_val("rstw_pend_clr", {63'd0, ld_pend}, 64'd0);
    check_val("rstw_instret", instret, 64'd0);
    check_val("rstw_orph_clr", {63'd0, rsp_orphan}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    settle();
    check_val("rstw_no_write", {63'd0, rf_we}, 64'd0);
    nxt();
    idle();
    settle();
    check_val("rstw_orph_set", {63'd0, rsp_orphan}, 64'd1);
    check_val("rstw_instret2", instret, 64'd0);

    // Response in the same cycle a load is captured is an orphan; the load keeps waiting
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    load(3'b100, 2'd1, 5'd13);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0000;
    nxt();
    idle();
    settle();
    check_val("capo_orph", {63'd0, rsp_orphan}, 64'd1);
    check_val("capo_pend", {63'd0, ld_pend}, 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_9A00;
    settle();
    check_val("lbu_wdata", {32'd0, rf_wdata}, 64'h0000_009A);
    nxt();
    idle();

    // Counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd4, 32'h0000_0001, 32'h0, 32'h0);
    settle();
    check_val("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    nxt();
    idle();
    nxt();
    settle();
    check_val("wrap_post", instret, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
